// File: rtl/sort_pkg.sv
// Shared helpers for the pipelined odd-even transposition sorter.
// Element widths up to CAS_MAX_W bits are supported.
package sort_pkg;

    localparam int unsigned CAS_MAX_W = 64;

    typedef logic [CAS_MAX_W-1:0] cas_word_t;

    typedef struct packed {
        cas_word_t lo;
        cas_word_t hi;
        logic      swapped;
    } cas_pair_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    // Swap only when strictly out of order, so equal keys keep their order.
    function automatic cas_pair_t cas_pair(input cas_word_t lo, input cas_word_t hi,
                                           input logic desc);
        cas_pair_t r;
        r.swapped = desc ? (lo < hi) : (lo > hi);
        r.lo      = r.swapped ? hi : lo;
        r.hi      = r.swapped ? lo : hi;
        return r;
    endfunction

endpackage

// File: rtl/sort_stage.sv
// One registered compare-swap layer of the transposition network.
// Optional index lanes are enabled by SORT_NET_INDEX_EN.
module sort_stage
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned ODD        = 0
`ifdef SORT_NET_INDEX_EN
    ,
    localparam int unsigned IDX_W = idx_width(NUM_INPUTS)
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          in_valid,
    input  logic                          in_desc,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
`ifdef SORT_NET_INDEX_EN
    input  logic [NUM_INPUTS*IDX_W-1:0]   in_index,
    output logic [NUM_INPUTS*IDX_W-1:0]   out_index,
`endif
    output logic                          out_valid,
    output logic                          out_desc,
    output logic [NUM_INPUTS*WIDTH-1:0]   out_data
);

    logic [NUM_INPUTS*WIDTH-1:0] lay_data;
    logic [NUM_INPUTS*WIDTH-1:0] data_d, data_q;
    logic                        valid_d, valid_q;
    logic                        desc_d, desc_q;
    logic                        unused_pair_bits;
`ifdef SORT_NET_INDEX_EN
    logic [NUM_INPUTS*IDX_W-1:0] lay_index;
    logic [NUM_INPUTS*IDX_W-1:0] index_d, index_q;
`endif

    always_comb begin
        cas_word_t lo_ext;
        cas_word_t hi_ext;
        cas_pair_t pr;
        lo_ext   = '0;
        hi_ext   = '0;
        pr       = '0;
        lay_data = in_data;
`ifdef SORT_NET_INDEX_EN
        lay_index = in_index;
`endif
        for (int unsigned k = ODD; k + 1 < NUM_INPUTS; k += 2) begin
            lo_ext = '0;
            hi_ext = '0;
            lo_ext[WIDTH-1:0] = in_data[k*WIDTH +: WIDTH];
            hi_ext[WIDTH-1:0] = in_data[(k+1)*WIDTH +: WIDTH];
            pr = cas_pair(lo_ext, hi_ext, in_desc);
            lay_data[k*WIDTH +: WIDTH]     = pr.lo[WIDTH-1:0];
            lay_data[(k+1)*WIDTH +: WIDTH] = pr.hi[WIDTH-1:0];
`ifdef SORT_NET_INDEX_EN
            if (pr.swapped) begin
                lay_index[k*IDX_W +: IDX_W]     = in_index[(k+1)*IDX_W +: IDX_W];
                lay_index[(k+1)*IDX_W +: IDX_W] = in_index[k*IDX_W +: IDX_W];
            end
`endif
        end
        // Zero-extension bits above WIDTH carry no information.
        unused_pair_bits = ^pr;

        data_d  = stall ? data_q  : lay_data;
        valid_d = stall ? valid_q : in_valid;
        desc_d  = stall ? desc_q  : in_desc;
`ifdef SORT_NET_INDEX_EN
        index_d = stall ? index_q : lay_index;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            desc_q  <= 1'b0;
`ifdef SORT_NET_INDEX_EN
            index_q <= '0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            desc_q  <= desc_d;
`ifdef SORT_NET_INDEX_EN
            index_q <= index_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_desc  = desc_q;
`ifdef SORT_NET_INDEX_EN
    assign out_index = index_q;
`endif

endmodule

// File: rtl/sort_net_pipe.sv
// Pipelined odd-even transposition sorter with valid/ready handshake.
// Define SORT_NET_INDEX_EN to add the out_index argsort output.
module sort_net_pipe
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NUM_INPUTS = 4
`ifdef SORT_NET_INDEX_EN
    ,
    localparam int unsigned IDX_W = idx_width(NUM_INPUTS)
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0]   in_data,
    input  logic                          in_desc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_INPUTS*WIDTH-1:0]   out_data,
`ifdef SORT_NET_INDEX_EN
    output logic [NUM_INPUTS*IDX_W-1:0]   out_index,
`endif
    output logic                          out_desc
);

    logic                        stall;
    logic [NUM_INPUTS:0]         valid_chain;
    logic [NUM_INPUTS:0]         desc_chain;
    logic [NUM_INPUTS*WIDTH-1:0] data_chain [NUM_INPUTS+1];
`ifdef SORT_NET_INDEX_EN
    logic [NUM_INPUTS*IDX_W-1:0] idx_init;
    logic [NUM_INPUTS*IDX_W-1:0] idx_chain [NUM_INPUTS+1];

    always_comb begin
        idx_init = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            idx_init[k*IDX_W +: IDX_W] = IDX_W'(k);
        end
    end

    assign idx_chain[0] = idx_init;
    assign out_index    = idx_chain[NUM_INPUTS];
`endif

    // A single global stall freezes every stage, so the output holds while blocked.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign valid_chain[0] = in_valid & in_ready;
    assign desc_chain[0]  = in_desc;
    assign data_chain[0]  = in_data;

    for (genvar s = 0; s < NUM_INPUTS; s++) begin : g_stage
        sort_stage #(
            .WIDTH      (WIDTH),
            .NUM_INPUTS (NUM_INPUTS),
            .ODD        (s % 2)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .stall     (stall),
            .in_valid  (valid_chain[s]),
            .in_desc   (desc_chain[s]),
            .in_data   (data_chain[s]),
`ifdef SORT_NET_INDEX_EN
            .in_index  (idx_chain[s]),
            .out_index (idx_chain[s+1]),
`endif
            .out_valid (valid_chain[s+1]),
            .out_desc  (desc_chain[s+1]),
            .out_data  (data_chain[s+1])
        );
    end

    assign out_valid = valid_chain[NUM_INPUTS];
    assign out_desc  = desc_chain[NUM_INPUTS];
    assign out_data  = data_chain[NUM_INPUTS];

endmodule

// File: doc/sort_net_pipe.md
Name: sort_net_pipe

Overview:
- Parametrised, pipelined successor to the combinational 4-input compare-and-swap sorter.
- Sorts NUM_INPUTS unsigned WIDTH-bit values through an odd-even transposition network, with one register stage per network layer.
- Valid/ready stream handshake with full backpressure; sort direction is selectable per beat.
- Sits between binary sources (stochastic-to-binary counters, comparators) and downstream median/rank logic.

Parameters:
- WIDTH, 4, bits per element (>=1).
- NUM_INPUTS, 4, element count (>=2; any integer, not only powers of two).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  NUM_INPUTS*WIDTH  flattened elements; element k at bits [k*WIDTH +: WIDTH].
- in_desc  input  1  1 = descending (element 0 largest), 0 = ascending.
- out_valid  output  1  sorted beat present.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  NUM_INPUTS*WIDTH  sorted elements, same packing as in_data.
- out_desc  output  1  direction the beat was sorted with.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Network: NUM_INPUTS layers. Layer s (s=0..NUM_INPUTS-1) compares pairs (k,k+1) with k even when s is even, and k odd when s is odd.
- Compare-swap rule: swap only when strictly out of order for that beat's direction (desc: lo<hi; asc: lo>hi). Equal values never swap, so the sort is stable.
- Pipelining:
  - Each layer output is registered with its own valid bit and desc bit.
  - Latency is NUM_INPUTS cycles from an accepted input to out_valid, with no stalls.
  - Throughput is 1 beat/cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational, no dependency on in_valid).
  - An input is accepted when in_valid & in_ready.
  - While stalled, all stages hold their data, valid and desc bits.
  - When not stalled, every stage advances; bubbles propagate as valid=0.
  - out_data, out_valid and out_desc stay stable while out_valid=1 and out_ready=0.
- Reset:
  - All stage valid bits clear to 0; out_valid=0 on the cycle after rst is sampled high.
  - Data and desc registers also reset to 0, so out_data=0 and out_desc=0.
  - in_ready=1 while out_valid=0.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Direction: in_desc travels with its beat, so beats of different direction may be interleaved back-to-back.
- Arithmetic: unsigned comparison over the full WIDTH; no widening.
- Boundaries:
  - NUM_INPUTS=2 gives one compare layer plus 1 extra pass-through layer (latency 2).
  - All-equal inputs pass unchanged.
  - Maximum values (all ones) compare correctly.

Optional Feature:
- Macro: SORT_NET_INDEX_EN.
- With the macro defined:
  - Adds output out_index, width NUM_INPUTS*IDX_W, where IDX_W = clog2(NUM_INPUTS).
  - Each slot carries the original input position of the corresponding out_data element (an argsort).
  - Indices swap together with data; ties keep the lower original index first.
- Without the macro: port absent; no index registers are synthesised.

Decomposition:
- Package sort_pkg:
  - clog2 function.
  - IDX_W derivation.
  - A cas_pair function returning the (lo,hi) ordered pair for a given direction.
- One natural sub-module, sort_stage:
  - Parameters: WIDTH, NUM_INPUTS, ODD (layer parity).
  - Contents: one layer of compare-swaps plus its registered data, valid, desc (and optional index).
  - Stall input acts as the hold enable.
- sort_net_pipe is a generate loop of NUM_INPUTS sort_stage instances plus the handshake logic.

Test Plan:
- Basic descending sort, defaults, out_ready=1: in_data {a=3,b=12,c=7,d=12} (element0..3), desc=1 -> exactly 4 cycles later out_valid=1, out_data elements {12,12,7,3}. With SORT_NET_INDEX_EN, out_index {1,3,2,0}.
- Ascending plus interleaving: back-to-back beats {5,0,15,9} desc=0 then {5,0,15,9} desc=1 -> consecutive outputs {0,5,9,15} (out_desc=0) then {15,9,5,0} (out_desc=1).
- Backpressure:
  - Stream 8 beats with out_ready low for cycles 6-9.
  - Required: in_ready low exactly while out_valid&~out_ready; out_data held constant; no beat lost or duplicated; output order matches input order.
- Reset mid-flight: 3 beats accepted, rst high for 1 cycle -> out_valid=0 from the next cycle on; none of the 3 beats ever appear at the output.
- Randomised 1000 beats for WIDTH=8 and NUM_INPUTS=5, with random valid and ready -> each output is a monotonic permutation of its input per out_desc, checked against a scoreboard model.
- Edge values: all inputs 15 (WIDTH=4) -> output unchanged (index identity if enabled). NUM_INPUTS=2, inputs {0,15}, desc=1 -> {15,0} after 2 cycles.
